// File: rtl/led_ctrl_pkg.sv
// Mode codes, state encoding and pattern constants shared by the LED pattern controller and the UART master decode.
package led_ctrl_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'd0;
  localparam logic [2:0] MODE_STATIC = 3'd1;
  localparam logic [2:0] MODE_BLINK  = 3'd2;
  localparam logic [2:0] MODE_ROTATE = 3'd3;
  localparam logic [2:0] MODE_COUNT  = 3'd4;

  localparam logic [3:0] ROTATE_SEED = 4'b0001;

  // State values equal the mode codes so the active mode can be reported straight from the state register.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STATIC = 3'd1,
    ST_BLINK  = 3'd2,
    ST_ROTATE = 3'd3,
    ST_COUNT  = 3'd4
  } led_state_t;

  function automatic logic mode_is_valid(input logic [2:0] mode);
    return (mode >= MODE_STATIC) && (mode <= MODE_COUNT);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Base-rate prescaler: counts 0..DIV-1 while enabled and flags the last count as a tick.
module led_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
    $error("led_tick_gen: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (i_clear || !i_enable || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tick = i_enable && (cnt == LAST);

endmodule

// File: rtl/led_pattern_controller.sv
// Drives 4 LEDs with a static, blinking, rotating or counting pattern selected by strobed commands.
module led_pattern_controller
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       i_axi_aclk_100MHZ,
  input  logic       i_axi_rst,
  input  logic [2:0] i_mode,
  input  logic [3:0] i_data,
  input  logic       i_data_valid,
  output logic [3:0] o_led,
  output logic [2:0] o_active_mode,
  output logic       o_cmd_err
);

  led_state_t state_q, state_d;
  logic [3:0] led_q, led_d;
  logic [3:0] data_q, data_d;
  logic [3:0] period_q, period_d;
  logic       err_q;
  logic       accept, reject, tick, timers_on;

  assign accept    = i_data_valid && mode_is_valid(i_mode);
  assign reject    = i_data_valid && !mode_is_valid(i_mode);
  assign timers_on = (state_q == ST_BLINK) || (state_q == ST_ROTATE) || (state_q == ST_COUNT);

  led_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .clk     (i_axi_aclk_100MHZ),
    .rst     (i_axi_rst),
    .i_clear (accept),
    .i_enable(timers_on),
    .o_tick  (tick)
  );

  always_ff @(posedge i_axi_aclk_100MHZ or posedge i_axi_rst) begin
    if (i_axi_rst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = led_state_t'(i_mode);
  end

  // A command on the same cycle as a step wins: the step is dropped and timers restart.
  always_comb begin
    led_d    = led_q;
    data_d   = data_q;
    period_d = period_q;
    if (accept) begin
      data_d   = i_data;
      period_d = 4'd0;
      case (i_mode)
        MODE_ROTATE: led_d = ROTATE_SEED;
        MODE_COUNT:  led_d = 4'h0;
        default:     led_d = i_data;
      endcase
    end else if (tick) begin
      if (period_q == data_q) begin
        period_d = 4'd0;
        case (state_q)
          ST_BLINK:  led_d = led_q ^ data_q;
          ST_ROTATE: led_d = {led_q[2:0], led_q[3]};
          ST_COUNT:  led_d = led_q + 4'd1;
          default:   led_d = led_q;
        endcase
      end else begin
        period_d = period_q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_axi_aclk_100MHZ or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      led_q    <= 4'h0;
      data_q   <= 4'h0;
      period_q <= 4'h0;
      err_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      data_q   <= data_d;
      period_q <= period_d;
      err_q    <= reject;
    end
  end

  assign o_led         = led_q;
  assign o_active_mode = state_q;
  assign o_cmd_err     = err_q;

endmodule
